monolith_perm_ctrl: RTL and testbench
=====================================

# monolith_perm_ctrl

Iterative round controller for the Monolith permutation. Accepts a full state over a valid/ready handshake and drives it through an external single-round datapath `NUM_ROUNDS` times, feeding each round's output back as the next round's input. Presents the final state over a second valid/ready handshake. Sits directly upstream of, and wraps around, the round datapath (bars → bricks → concrete). Also exports the round index the datapath uses for constant selection.

## Interface
- `WORD_WIDTH`, 31: field element width; modulus p = 2^WORD_WIDTH − 1.
- `STATE_SIZE`, 16: state words.
- `NUM_ROUNDS`, 6: round iterations per permutation (≥1).
- `ROUND_LATENCY`, 1: register stages in the round datapath (≥0; 0 = combinational).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `in_valid` in 1: input state valid.
- `in_ready` out 1: controller accepts input.
- `in_state` in `[WORD_WIDTH-1:0] [0:STATE_SIZE-1]`: permutation input.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_state` out `[WORD_WIDTH-1:0] [0:STATE_SIZE-1]`: permutation result.
- `rnd_state_out` out, same array type: state driven into the round datapath.
- `rnd_state_in` in, same array type: round datapath output.
- `round_idx` out `$clog2(NUM_ROUNDS)` (min 1 bit): current round number.
- `last_round` out 1: high while `round_idx == NUM_ROUNDS-1` in RUN.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM with three states.
  - IDLE: `in_ready=1`. On `in_valid & in_ready`: `state_reg<=in_state`, `orig_reg<=in_state`, `round_cnt<=0`, `lat_cnt<=0`, go to RUN.
  - RUN: `rnd_state_out=state_reg`, held stable for the whole round. `lat_cnt` increments each cycle. When `lat_cnt==ROUND_LATENCY`, capture `rnd_state_in`, then:
    - if `round_cnt==NUM_ROUNDS-1`: `result_reg<=` captured value (after feed-forward when enabled), go to DONE;
    - else `state_reg<=` captured value, `round_cnt++`, `lat_cnt<=0`.
  - DONE: `out_valid=1`, `out_state=result_reg`. On `out_ready`: go to IDLE.
- `in_ready` is high only in IDLE, so permutations never overlap. An input offered in the cycle DONE completes is accepted on the following cycle (IDLE).
- `round_idx=round_cnt` in RUN, 0 otherwise. `last_round` is 0 outside RUN.
- `rnd_state_out` is `state_reg` in every state. The round datapath sees stale data outside RUN; this is harmless.
- `out_state` holds `result_reg` in all states; it is only meaningful while `out_valid` is high.
- Reset at any point, including mid-RUN or in DONE with `out_ready` low: abort, return to IDLE, and clear all registers. The in-flight result is discarded.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `round_idx=0`, `last_round=0`, `out_state` all zeros, `rnd_state_out` all zeros.
- Accept edge at cycle 0. RUN occupies cycles 1 … `NUM_ROUNDS*(ROUND_LATENCY+1)`. `out_valid` rises in the next cycle.
  - Defaults: accept at cycle 0, `out_valid` at cycle 13.
- `out_valid` and `out_state` stay stable until the `out_ready` handshake.
- Back-to-back throughput: one permutation per `NUM_ROUNDS*(ROUND_LATENCY+1)+2` cycles with `out_ready` held high.

## Configuration
- `MONOLITH_FEED_FORWARD_EN` defined: `result = perm(in) + in`, computed element-wise mod p.
  - Form the `WORD_WIDTH+1`-bit sum s.
  - Fold: `r = s[W-1:0] + s[W]`.
  - If `r == p`, output 0.
  - `orig_reg` is instantiated and adds one cycle of nothing: the adder is combinational into `result_reg`, so latency is unchanged.
- Undefined: `result = perm(in)`. `orig_reg` and the adders are not instantiated.

## Structure
- Shared package `monolith_pkg`:
  - modulus constant;
  - FSM state enum (`IDLE`, `RUN`, `DONE`);
  - defaults for `NUM_ROUNDS` and `ROUND_LATENCY`.
- One sub-module, `monolith_mod_add`: single-word addition mod p with fold and canonicalisation. It is used only under `MONOLITH_FEED_FORWARD_EN`, instantiated `STATE_SIZE` times.
- The round datapath is not instantiated here; the top level connects it via `rnd_state_out` and `rnd_state_in`.

## Test plan
Bench round stub: each word +1 mod p, with `ROUND_LATENCY` register stages.
- Defaults, macro off, `in_state` all 0 → `out_state` all 6; `out_valid` rises 13 cycles after accept; `round_idx` steps 0..5; `last_round` high only on round 5.
- `ROUND_LATENCY=0`, `in_state` all 0x7FFFFFFE → all 5 (wrap through p) after 6 RUN cycles.
- Macro on, `in_state` all 5 → all 16. Word 0x7FFFFFFE → 4. Separately, the `monolith_mod_add` unit check 1 + 0x7FFFFFFE → 0.
- Hold `out_ready=0` for 20 cycles in DONE → `out_valid` and `out_state` stable, `in_ready=0`. Raise `out_ready` → IDLE on the next edge, then accept a queued input.
- Assert `reset=0` at round 3 → next edge: `busy=0`, `in_ready=1`, `round_idx=0`, `out_valid` never rises for the aborted input.
- `in_valid` held high continuously with `out_ready=1` → one accept every 14 cycles, results in order.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared constants and types for the Monolith round controller.
// Feed-forward option is selected in the top level with MONOLITH_FEED_FORWARD_EN.
package monolith_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH    = 31;
    localparam int unsigned DEFAULT_STATE_SIZE    = 16;
    localparam int unsigned DEFAULT_NUM_ROUNDS    = 6;
    localparam int unsigned DEFAULT_ROUND_LATENCY = 1;

    // Mersenne prime p = 2^31 - 1 for the default word width.
    localparam logic [30:0] MODULUS = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/monolith_mod_add.sv
// Single-word addition modulo the Mersenne prime 2^WORD_WIDTH - 1,
// with end-around-carry fold and canonicalisation of p to 0.
module monolith_mod_add #(
    parameter int WORD_WIDTH = 31
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] sum
);

    localparam logic [WORD_WIDTH-1:0] P = {WORD_WIDTH{1'b1}};

    logic [WORD_WIDTH:0]   wide_s;
    logic [WORD_WIDTH-1:0] fold_s;

    // 2^W == 1 mod p, so the carry folds back in; the fold cannot overflow for inputs <= p.
    always_comb begin
        wide_s = {1'b0, a} + {1'b0, b};
        fold_s = wide_s[WORD_WIDTH-1:0] + {{(WORD_WIDTH-1){1'b0}}, wide_s[WORD_WIDTH]};
        if (fold_s == P) begin
            sum = {WORD_WIDTH{1'b0}};
        end else begin
            sum = fold_s;
        end
    end

endmodule

// File: rtl/monolith_perm_ctrl.sv
// Iterative round controller for the Monolith permutation around an external round datapath.
// Define MONOLITH_FEED_FORWARD_EN to add the input state to the result (mod p).
module monolith_perm_ctrl
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int STATE_SIZE    = DEFAULT_STATE_SIZE,
    parameter int NUM_ROUNDS    = DEFAULT_NUM_ROUNDS,
    parameter int ROUND_LATENCY = DEFAULT_ROUND_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_state      [0:STATE_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_state     [0:STATE_SIZE-1],
    output logic [WORD_WIDTH-1:0] rnd_state_out [0:STATE_SIZE-1],
    input  logic [WORD_WIDTH-1:0] rnd_state_in  [0:STATE_SIZE-1],
    output logic [((NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1)-1:0] round_idx,
    output logic                  last_round,
    output logic                  busy
);

    localparam int IDX_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam int LAT_W = (ROUND_LATENCY > 0) ? $clog2(ROUND_LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(ROUND_LATENCY);

    ctrl_state_t          cur_r;
    ctrl_state_t          nxt_s;
    logic [IDX_W-1:0]     round_cnt_r;
    logic [LAT_W-1:0]     lat_cnt_r;
    logic [WORD_WIDTH-1:0] state_r  [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] result_r [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] final_s  [0:STATE_SIZE-1];

    logic accept_s;
    logic round_end_s;
    logic is_last_s;

    assign accept_s    = (cur_r == IDLE) && in_valid;
    assign round_end_s = (cur_r == RUN) && (lat_cnt_r == LAT_END);
    assign is_last_s   = (round_cnt_r == LAST_IDX);

    assign rnd_state_out = state_r;
    assign out_state     = result_r;

`ifdef MONOLITH_FEED_FORWARD_EN
    logic [WORD_WIDTH-1:0] orig_r   [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] ff_sum_s [0:STATE_SIZE-1];

    // Original input held for the feed-forward addition after the last round.
    always_ff @(posedge clk) begin
        if (!reset) begin
            orig_r <= '{default: {WORD_WIDTH{1'b0}}};
        end else if (accept_s) begin
            orig_r <= in_state;
        end
    end

    for (genvar g = 0; g < STATE_SIZE; g++) begin : g_ff_add
        monolith_mod_add #(
            .WORD_WIDTH (WORD_WIDTH)
        ) u_ff_add (
            .a   (rnd_state_in[g]),
            .b   (orig_r[g]),
            .sum (ff_sum_s[g])
        );
    end

    assign final_s = ff_sum_s;
`else
    assign final_s = rnd_state_in;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_r <= IDLE;
        end else begin
            cur_r <= nxt_s;
        end
    end

    // Next-state selection and state-decoded handshake/status outputs.
    always_comb begin
        nxt_s      = cur_r;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        round_idx  = {IDX_W{1'b0}};
        last_round = 1'b0;
        case (cur_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nxt_s = RUN;
                end else begin
                    nxt_s = IDLE;
                end
            end
            RUN: begin
                busy       = 1'b1;
                round_idx  = round_cnt_r;
                last_round = is_last_s;
                if (round_end_s && is_last_s) begin
                    nxt_s = DONE;
                end else begin
                    nxt_s = RUN;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    nxt_s = IDLE;
                end else begin
                    nxt_s = DONE;
                end
            end
            default: begin
                nxt_s = IDLE;
            end
        endcase
    end

    // Round/latency counters and state/result capture; state_r is held for the whole round.
    always_ff @(posedge clk) begin
        if (!reset) begin
            round_cnt_r <= {IDX_W{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            state_r     <= '{default: {WORD_WIDTH{1'b0}}};
            result_r    <= '{default: {WORD_WIDTH{1'b0}}};
        end else if (accept_s) begin
            round_cnt_r <= {IDX_W{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            state_r     <= in_state;
        end else if (cur_r == RUN) begin
            if (round_end_s) begin
                if (is_last_s) begin
                    result_r <= final_s;
                end else begin
                    state_r     <= rnd_state_in;
                    round_cnt_r <= round_cnt_r + IDX_W'(1);
                    lat_cnt_r   <= {LAT_W{1'b0}};
                end
            end else begin
                lat_cnt_r <= lat_cnt_r + LAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Self-checking bench for monolith_perm_ctrl with a "+1 mod p" round stub.
// Honours MONOLITH_FEED_FORWARD_EN in its reference model.
module tb_monolith_perm_ctrl;

    localparam int W = 31, S = 16, NR = 6, LAT = 1;
    localparam longint unsigned P = 64'h7FFF_FFFF;
    localparam int RUN_CYC = NR * (LAT + 1);

    typedef logic [W-1:0] word_t;
    typedef word_t vec_t [0:S-1];

    logic  clk = 1'b0;
    logic  reset;
    logic  in_valid, in_ready, out_valid, out_ready, last_round, busy;
    vec_t  in_state, out_state, rnd_out, rnd_in;
    logic [2:0] round_idx;

    logic  in_valid0, in_ready0, out_valid0, out_ready0, last_round0, busy0;
    vec_t  in_state0, out_state0, rnd_out0, rnd_in0;
    logic [2:0] round_idx0;

    word_t ma_a, ma_b, ma_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    monolith_perm_ctrl #(.WORD_WIDTH(W), .STATE_SIZE(S), .NUM_ROUNDS(NR), .ROUND_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .rnd_state_out(rnd_out), .rnd_state_in(rnd_in), .round_idx(round_idx),
        .last_round(last_round), .busy(busy)
    );

    monolith_perm_ctrl #(.WORD_WIDTH(W), .STATE_SIZE(S), .NUM_ROUNDS(NR), .ROUND_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_state(in_state0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_state(out_state0),
        .rnd_state_out(rnd_out0), .rnd_state_in(rnd_in0), .round_idx(round_idx0),
        .last_round(last_round0), .busy(busy0)
    );

    monolith_mod_add #(.WORD_WIDTH(W)) u_add (.a(ma_a), .b(ma_b), .sum(ma_sum));

    function automatic word_t stub_inc(input word_t x);
        longint unsigned v;
        v = x;
        return word_t'((v + 1) % P);
    endfunction

    // Round stubs: one register stage for dut, combinational for dut0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < S; i++) rnd_in[i] <= stub_inc(rnd_out[i]);
    end

    always_comb begin
        for (int i = 0; i < S; i++) rnd_in0[i] = stub_inc(rnd_out0[i]);
    end

    // Reference: NR increments mod p, optionally plus the input mod p.
    function automatic word_t model_word(input word_t x);
        longint unsigned v, xi;
        xi = x;
        v  = (xi + NR) % P;
`ifdef MONOLITH_FEED_FORWARD_EN
        v  = (v + xi) % P;
`endif
        return word_t'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < S; i++) v[i] = word_t'($urandom_range(32'h7FFF_FFFE, 32'h0));
    endtask

    task automatic run_perm(input vec_t st, output int lat, output vec_t res);
        int k;
        in_state = st;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin step(); k++; end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        res = out_state;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int badw;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        for (int i = 0; i < S; i++) begin in_state[i] = '0; in_state0[i] = '0; end
        repeat (3) step();
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (round_idx !== 3'd0)  begin bad++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
        total++; if (last_round !== 1'b0) begin bad++; $display("FAIL reset_last_round: got %b want 0", last_round); end
        badw = -1;
        for (int i = 0; i < S; i++) if (out_state[i] !== '0 || rnd_out[i] !== '0) badw = i;
        total++; if (badw >= 0) begin bad++; $display("FAIL reset_arrays: word %0d out=%h rnd=%h want 0", badw, out_state[badw], rnd_out[badw]); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_defaults();
        int n, exp_idx, badw;
        for (int i = 0; i < S; i++) in_state[i] = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            exp_idx = (n - 1) / (LAT + 1);
            total++; if (round_idx !== 3'(exp_idx)) begin bad++; $display("FAIL round_idx_c%0d: got %0d want %0d", n, round_idx, exp_idx); end
            total++; if (last_round !== (exp_idx == NR - 1)) begin bad++; $display("FAIL last_round_c%0d: got %b want %b", n, last_round, exp_idx == NR - 1); end
            step();
            n++;
        end
        total++; if (n !== RUN_CYC + 1) begin bad++; $display("FAIL zero_latency: got %0d want %0d", n, RUN_CYC + 1); end
        badw = -1;
        for (int i = 0; i < S; i++) if (out_state[i] !== model_word('0)) badw = i;
        total++; if (badw >= 0) begin bad++; $display("FAIL zero_result: word %0d got %h want %h", badw, out_state[badw], model_word('0)); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL release_to_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_lat0();
        vec_t v;
        int n, badw;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) for (int i = 0; i < S; i++) v[i] = 31'h7FFF_FFFE;
            else rand_vec(v);
            in_state0 = v;
            in_valid0 = 1'b1;
            step();
            in_valid0 = 1'b0;
            n = 1;
            while (!out_valid0 && n < 100) begin step(); n++; end
            total++; if (n !== NR + 1) begin bad++; $display("FAIL lat0_latency_t%0d: got %0d want %0d", t, n, NR + 1); end
            badw = -1;
            for (int i = 0; i < S; i++) if (out_state0[i] !== model_word(v[i])) badw = i;
            total++; if (badw >= 0) begin bad++; $display("FAIL lat0_result_t%0d: word %0d got %h want %h", t, badw, out_state0[badw], model_word(v[badw])); end
            out_ready0 = 1'b1;
            step();
            out_ready0 = 1'b0;
        end
    endtask

    task automatic test_values();
        vec_t v, res;
        int lat, badw;
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin
                for (int i = 0; i < S; i++)
                    case (i % 4)
                        0: v[i] = 31'd5;
                        1: v[i] = 31'h7FFF_FFFE;
                        2: v[i] = 31'h7FFF_FFFA;
                        default: v[i] = 31'd0;
                    endcase
            end else begin
                rand_vec(v);
            end
            run_perm(v, lat, res);
            total++; if (lat !== RUN_CYC + 1) begin bad++; $display("FAIL value_latency_t%0d: got %0d want %0d", t, lat, RUN_CYC + 1); end
            badw = -1;
            for (int i = 0; i < S; i++) if (res[i] !== model_word(v[i])) badw = i;
            total++; if (badw >= 0) begin bad++; $display("FAIL value_result_t%0d: word %0d got %h want %h", t, badw, res[badw], model_word(v[badw])); end
        end
    endtask

    task automatic test_mod_add();
        word_t exp_s;
        longint unsigned a64, b64;
        for (int t = 0; t < 8; t++) begin
            case (t)
                0: begin ma_a = 31'd1;          ma_b = 31'h7FFF_FFFE; end
                1: begin ma_a = 31'h7FFF_FFFE;  ma_b = 31'h7FFF_FFFE; end
                2: begin ma_a = 31'd0;          ma_b = 31'd0;         end
                default: begin
                    ma_a = word_t'($urandom_range(32'h7FFF_FFFE, 32'h0));
                    ma_b = word_t'($urandom_range(32'h7FFF_FFFE, 32'h0));
                end
            endcase
            #1;
            a64 = ma_a; b64 = ma_b;
            exp_s = word_t'((a64 + b64) % P);
            total++; if (ma_sum !== exp_s) begin bad++; $display("FAIL mod_add_t%0d: %h+%h got %h want %h", t, ma_a, ma_b, ma_sum, exp_s); end
        end
    endtask

    task automatic test_hold();
        vec_t a, q, snap;
        int k, n, badw;
        logic stable;
        rand_vec(a); rand_vec(q);
        in_state = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin step(); k++; end
        snap = out_state;
        badw = -1;
        for (int i = 0; i < S; i++) if (snap[i] !== model_word(a[i])) badw = i;
        total++; if (badw >= 0) begin bad++; $display("FAIL hold_result: word %0d got %h want %h", badw, snap[badw], model_word(a[badw])); end
        in_state = q; in_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            for (int i = 0; i < S; i++) if (out_state[i] !== snap[i]) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL hold_stable: got %b want 1", stable); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        step();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL queued_accept: busy got %b want 1", busy); end
        n = 1;
        while (!out_valid && n < 100) begin step(); n++; end
        total++; if (n !== RUN_CYC + 1) begin bad++; $display("FAIL queued_latency: got %0d want %0d", n, RUN_CYC + 1); end
        badw = -1;
        for (int i = 0; i < S; i++) if (out_state[i] !== model_word(q[i])) badw = i;
        total++; if (badw >= 0) begin bad++; $display("FAIL queued_result: word %0d got %h want %h", badw, out_state[badw], model_word(q[badw])); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        vec_t a;
        int k, badw;
        logic rose;
        rand_vec(a);
        in_state = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (round_idx !== 3'd3 && k < 40) begin step(); k++; end
        total++; if (round_idx !== 3'd3) begin bad++; $display("FAIL reach_round3: got %0d want 3", round_idx); end
        reset = 1'b0;
        step();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        total++; if (round_idx !== 3'd0) begin bad++; $display("FAIL abort_round_idx: got %0d want 0", round_idx); end
        badw = -1;
        for (int i = 0; i < S; i++) if (rnd_out[i] !== '0) badw = i;
        total++; if (badw >= 0) begin bad++; $display("FAIL abort_clear: word %0d got %h want 0", badw, rnd_out[badw]); end
        reset = 1'b1;
        rose = 1'b0;
        repeat (20) begin step(); if (out_valid !== 1'b0) rose = 1'b1; end
        total++; if (rose !== 1'b0) begin bad++; $display("FAIL abort_no_output: out_valid rose=%b want 0", rose); end
    endtask

    task automatic test_back_to_back();
        vec_t vecs [0:3];
        int acc_cyc [0:3];
        int cyc, n_acc, n_out, badw;
        logic acc_now;
        for (int j = 0; j < 4; j++) rand_vec(vecs[j]);
        cyc = 0; n_acc = 0; n_out = 0;
        in_state = vecs[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (n_out < 4 && cyc < 300) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                badw = -1;
                for (int i = 0; i < S; i++) if (out_state[i] !== model_word(vecs[n_out][i])) badw = i;
                total++; if (badw >= 0) begin bad++; $display("FAIL b2b_result_%0d: word %0d got %h want %h", n_out, badw, out_state[badw], model_word(vecs[n_out][badw])); end
                n_out++;
            end
            step();
            cyc++;
            if (acc_now) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) in_state = vecs[n_acc];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (n_out !== 4 || n_acc !== 4) begin bad++; $display("FAIL b2b_count: outputs=%0d accepts=%0d want 4/4", n_out, n_acc); end
        for (int j = 1; j < n_acc; j++) begin
            total++; if (acc_cyc[j] - acc_cyc[j-1] !== RUN_CYC + 2) begin
                bad++; $display("FAIL b2b_spacing_%0d: got %0d want %0d", j, acc_cyc[j] - acc_cyc[j-1], RUN_CYC + 2);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_lat0();
        test_values();
        test_mod_add();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
